tl_tx_wrr_arb: RTL and testbench

TL_TX_WRR_ARB -- requirements
Module: tl_tx_wrr_arb

---
 rtl/tl_tx_wrr_arb.sv | 224 ++++++++++++++++++++++
 tb/tb_tl_tx_wrr_arb.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_tx_wrr_arb.sv
// tl_tx_wrr_arb -- weighted round-robin arbiter for TLP transmit queues.
//
// Picks one of NUM_Q packet queues (0 = Cpl, 1 = NP, 2 = Posted) and forwards
// its packet beats to a single downstream stream. A queue may start a packet
// only when its header (and, for data-bearing TLPs, data) credit is available.
// Each grant emits a one-cycle registered consume pulse carrying the header
// count and data DW count taken from the granted header.
//
// Optional feature: define TL_TX_ARB_STARVE_EN to add per-queue age counters
// that force a grant to any queue that has waited STARVE_MAX grant cycles.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   pkt_i/pkt_valid_i   per-queue head beat and valid
//   pkt_ready_o         per-queue beat accept
//   hdr_credit_ok_i     per-queue header credit available
//   data_credit_ok_i    per-queue data credit available
//   weight_i            per-queue max packets per turn (0 = disabled)
//   hdr_consume_v_o     one-header consume pulse
//   data_consume_v_o    data consume pulse
//   data_consume_dw_o   DWs consumed, valid with data_consume_v_o
//   tl_tx_o/_valid_o    arbitrated beat; tl_tx_ready_i downstream ready
//   grant_o             one-hot grant, zero while idle
//   proto_err_o         sticky: non-sop beat seen at a queue head while idle

package tl_pkg;
  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [63:0] data;
  } tl_stream_t;
endpackage

module tl_tx_wrr_arb #(
  parameter int NUM_Q      = 3,
  parameter int WEIGHT_W   = 4,
  parameter int DCRED_W    = 12,
  parameter int STARVE_MAX = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  tl_pkg::tl_stream_t [NUM_Q-1:0]   pkt_i,
  input  logic [NUM_Q-1:0]                 pkt_valid_i,
  output logic [NUM_Q-1:0]                 pkt_ready_o,
  input  logic [NUM_Q-1:0]                 hdr_credit_ok_i,
  input  logic [NUM_Q-1:0]                 data_credit_ok_i,
  input  logic [NUM_Q*WEIGHT_W-1:0]        weight_i,
  output logic [NUM_Q-1:0]                 hdr_consume_v_o,
  output logic [NUM_Q-1:0]                 data_consume_v_o,
  output logic [NUM_Q*DCRED_W-1:0]         data_consume_dw_o,
  output tl_pkg::tl_stream_t               tl_tx_o,
  output logic                             tl_tx_valid_o,
  input  logic                             tl_tx_ready_i,
  output logic [NUM_Q-1:0]                 grant_o,
  output logic                             proto_err_o
);

  localparam int IDX_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t                   state_reg, state_next;
  logic [IDX_W-1:0]         ptr_reg, ptr_next;
  logic [IDX_W-1:0]         gidx_reg, gidx_next;
  logic [WEIGHT_W-1:0]      burst_reg, burst_next;
  logic [NUM_Q-1:0]         grant_reg, grant_next;
  logic [NUM_Q-1:0]         hdr_cons_reg, hdr_cons_next;
  logic [NUM_Q-1:0]         data_cons_reg, data_cons_next;
  logic [NUM_Q*DCRED_W-1:0] dw_reg, dw_next;
  logic                     proto_err_reg, proto_err_next;

  logic [WEIGHT_W-1:0]      weight [NUM_Q];
  logic [NUM_Q-1:0]         has_data, elig, bad_sop, starve;
  logic [IDX_W-1:0]         sel_idx;
  logic [WEIGHT_W-1:0]      sel_burst;
  logic                     any_elig, keep, arb_fire;
  logic [9:0]               len10;
  logic [DCRED_W-1:0]       len_dw;

  generate
    for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_q
      assign weight[gi]   = weight_i[gi*WEIGHT_W +: WEIGHT_W];
      assign has_data[gi] = pkt_i[gi].data[6];
      assign elig[gi]     = pkt_valid_i[gi] & pkt_i[gi].sop & hdr_credit_ok_i[gi] &
                            (~has_data[gi] | data_credit_ok_i[gi]) & (weight[gi] != '0);
      assign bad_sop[gi]  = pkt_valid_i[gi] & ~pkt_i[gi].sop;
    end
  endgenerate

  assign any_elig = |elig;
  assign arb_fire = (state_reg == IDLE) && any_elig;

`ifdef TL_TX_ARB_STARVE_EN
  localparam int AGE_W = $clog2(STARVE_MAX + 1);
  logic [AGE_W-1:0] age_reg [NUM_Q];

  generate
    for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_age
      assign starve[gi] = elig[gi] && (age_reg[gi] == AGE_W'(STARVE_MAX));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          age_reg[gi] <= '0;
        end else if (arb_fire) begin
          if (sel_idx == IDX_W'(gi))
            age_reg[gi] <= '0;
          else if (elig[gi] && (age_reg[gi] != AGE_W'(STARVE_MAX)))
            age_reg[gi] <= age_reg[gi] + AGE_W'(1);
        end
      end
    end
  endgenerate
`else
  assign starve = '0;
`endif

  // WRR selection. burst_reg == 0 only after reset, meaning no turn is in
  // progress, so the first scan starts at ptr+1 = queue 0.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cidx;
    sel_idx = ptr_reg;
    found   = 1'b0;
    cidx    = '0;
    keep    = (burst_reg != '0) && elig[ptr_reg] && (burst_reg < weight[ptr_reg]);
    for (int k = NUM_Q - 1; k >= 0; k--) begin
      if (starve[k]) begin
        sel_idx = IDX_W'(k);
        found   = 1'b1;
      end
    end
    if (!found && keep) begin
      sel_idx = ptr_reg;
      found   = 1'b1;
    end
    for (int k = 1; k <= NUM_Q; k++) begin
      cidx = IDX_W'((int'(ptr_reg) + k) % NUM_Q);
      if (!found && elig[cidx]) begin
        sel_idx = cidx;
        found   = 1'b1;
      end
    end
    sel_burst = (keep && (sel_idx == ptr_reg)) ? burst_reg + WEIGHT_W'(1) : WEIGHT_W'(1);
  end

  assign len10  = {pkt_i[sel_idx].data[17:16], pkt_i[sel_idx].data[31:24]};
  assign len_dw = (len10 == '0) ? DCRED_W'(1024) : DCRED_W'(len10);

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    gidx_next      = gidx_reg;
    burst_next     = burst_reg;
    grant_next     = grant_reg;
    hdr_cons_next  = '0;
    data_cons_next = '0;
    dw_next        = '0;
    proto_err_next = proto_err_reg | ((state_reg == IDLE) && (|bad_sop));
    case (state_reg)
      IDLE: begin
        if (any_elig) begin
          state_next              = XFER;
          ptr_next                = sel_idx;
          gidx_next               = sel_idx;
          burst_next              = sel_burst;
          grant_next              = {{(NUM_Q-1){1'b0}}, 1'b1} << sel_idx;
          hdr_cons_next[sel_idx]  = 1'b1;
          data_cons_next[sel_idx] = has_data[sel_idx];
          if (has_data[sel_idx])
            dw_next[sel_idx*DCRED_W +: DCRED_W] = len_dw;
        end
      end
      XFER: begin
        if (pkt_valid_i[gidx_reg] && tl_tx_ready_i && pkt_i[gidx_reg].eop) begin
          state_next = IDLE;
          grant_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= IDX_W'(NUM_Q - 1);
      gidx_reg      <= '0;
      burst_reg     <= '0;
      grant_reg     <= '0;
      hdr_cons_reg  <= '0;
      data_cons_reg <= '0;
      dw_reg        <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      gidx_reg      <= gidx_next;
      burst_reg     <= burst_next;
      grant_reg     <= grant_next;
      hdr_cons_reg  <= hdr_cons_next;
      data_cons_reg <= data_cons_next;
      dw_reg        <= dw_next;
      proto_err_reg <= proto_err_next;
    end
  end

  always_comb begin
    tl_tx_o       = '0;
    tl_tx_valid_o = 1'b0;
    pkt_ready_o   = '0;
    if (state_reg == XFER) begin
      tl_tx_o               = pkt_i[gidx_reg];
      tl_tx_valid_o         = pkt_valid_i[gidx_reg];
      pkt_ready_o[gidx_reg] = tl_tx_ready_i;
    end
  end

  assign grant_o           = grant_reg;
  assign hdr_consume_v_o   = hdr_cons_reg;
  assign data_consume_v_o  = data_cons_reg;
  assign data_consume_dw_o = dw_reg;
  assign proto_err_o       = proto_err_reg;

endmodule

// File: tb/tb_tl_tx_wrr_arb.sv
module tb_tl_tx_wrr_arb;
  import tl_pkg::*;

  localparam int NQ = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  tl_stream_t [NQ-1:0]   pkt_i;
  logic [NQ-1:0]         pkt_valid_i;
  logic [NQ-1:0]         pkt_ready_o;
  logic [NQ-1:0]         hdr_credit_ok_i;
  logic [NQ-1:0]         data_credit_ok_i;
  logic [NQ*4-1:0]       weight_i;
  logic [NQ-1:0]         hdr_consume_v_o;
  logic [NQ-1:0]         data_consume_v_o;
  logic [NQ*12-1:0]      data_consume_dw_o;
  tl_stream_t            tl_tx_o;
  logic                  tl_tx_valid_o;
  logic                  tl_tx_ready_i;
  logic [NQ-1:0]         grant_o;
  logic                  proto_err_o;

  tl_tx_wrr_arb #(.NUM_Q(NQ), .WEIGHT_W(4), .DCRED_W(12), .STARVE_MAX(64)) dut (
    .clk(clk), .rst_n(rst_n), .pkt_i(pkt_i), .pkt_valid_i(pkt_valid_i),
    .pkt_ready_o(pkt_ready_o), .hdr_credit_ok_i(hdr_credit_ok_i),
    .data_credit_ok_i(data_credit_ok_i), .weight_i(weight_i),
    .hdr_consume_v_o(hdr_consume_v_o), .data_consume_v_o(data_consume_v_o),
    .data_consume_dw_o(data_consume_dw_o), .tl_tx_o(tl_tx_o),
    .tl_tx_valid_o(tl_tx_valid_o), .tl_tx_ready_i(tl_tx_ready_i),
    .grant_o(grant_o), .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {int q; logic sop; logic eop; logic [63:0] data;} exp_beat_t;
  typedef struct {logic [2:0] hdr; logic [2:0] dv; logic [35:0] dw;} exp_cons_t;

  tl_stream_t src_q [NQ][$];
  exp_beat_t  exp_beat[$];
  exp_cons_t  exp_cons[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         mon_beats = 0;
  logic [NQ-1:0] drv_fire;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] mk_hdr(input logic [15:0] tag, input logic hd, input logic [9:0] len);
    logic [63:0] d;
    d = '0;
    d[63:48] = tag;
    d[6]     = hd;
    d[31:24] = len[7:0];
    d[17:16] = len[9:8];
    return d;
  endfunction

  function automatic logic [63:0] mk_dat(input logic [15:0] tag);
    logic [63:0] d;
    d = '0;
    d[63:48] = tag;
    return d;
  endfunction

  task automatic load(input int q, input logic sop, input logic eop, input logic [63:0] d);
    tl_stream_t b;
    b.sop = sop; b.eop = eop; b.data = d;
    src_q[q].push_back(b);
  endtask

  task automatic expb(input int q, input logic sop, input logic eop, input logic [63:0] d);
    exp_beat_t e;
    e.q = q; e.sop = sop; e.eop = eop; e.data = d;
    exp_beat.push_back(e);
  endtask

  task automatic expc(input logic [2:0] hdr, input logic [2:0] dv, input logic [35:0] dw);
    exp_cons_t c;
    c.hdr = hdr; c.dv = dv; c.dw = dw;
    exp_cons.push_back(c);
  endtask

  // Source driver: pops a queue head once its beat was accepted.
  initial begin
    pkt_i = '0;
    pkt_valid_i = '0;
    forever begin
      @(negedge clk);
      drv_fire = pkt_valid_i & pkt_ready_o;
      @(posedge clk);
      #1;
      for (int q = 0; q < NQ; q++) begin
        if (drv_fire[q] && src_q[q].size() > 0) void'(src_q[q].pop_front());
        if (src_q[q].size() > 0) begin
          pkt_i[q] = src_q[q][0];
          pkt_valid_i[q] = 1'b1;
        end else begin
          pkt_i[q] = '0;
          pkt_valid_i[q] = 1'b0;
        end
      end
    end
  end

  // Monitor: compares every transferred beat and every consume pulse.
  initial begin
    exp_beat_t e;
    exp_cons_t c;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (tl_tx_valid_o && tl_tx_ready_i) begin
          mon_beats++;
          if (exp_beat.size() == 0) begin
            chk("unexpected_beat", tl_tx_o.data, 64'h0);
            chk("unexpected_beat_grant", 64'(grant_o), 64'h0);
          end else begin
            e = exp_beat.pop_front();
            $display("beat q=%0d data=%h sop=%0b eop=%0b", e.q, tl_tx_o.data, tl_tx_o.sop, tl_tx_o.eop);
            chk("beat_grant", 64'(grant_o), 64'(3'b001 << e.q));
            chk("beat_data", tl_tx_o.data, e.data);
            chk("beat_flags", 64'({tl_tx_o.sop, tl_tx_o.eop}), 64'({e.sop, e.eop}));
          end
        end
        if (hdr_consume_v_o != '0 || data_consume_v_o != '0) begin
          if (exp_cons.size() == 0) begin
            chk("unexpected_consume", 64'(hdr_consume_v_o), 64'h0);
          end else begin
            c = exp_cons.pop_front();
            $display("consume hdr=%b data=%b dw=%h", hdr_consume_v_o, data_consume_v_o, data_consume_dw_o);
            chk("cons_hdr", 64'(hdr_consume_v_o), 64'(c.hdr));
            chk("cons_dv", 64'(data_consume_v_o), 64'(c.dv));
            chk("cons_dw", 64'(data_consume_dw_o), 64'(c.dw));
          end
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((exp_beat.size() != 0 || exp_cons.size() != 0) && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain_timeout", 64'(exp_beat.size() + exp_cons.size()), 64'h0);
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (mon_beats < target && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("beat_wait_timeout", 64'(mon_beats >= target), 64'h1);
  endtask

  initial begin
    int b0;
    rst_n = 1'b0;
    tl_tx_ready_i = 1'b1;
    hdr_credit_ok_i = '1;
    data_credit_ok_i = '1;
    weight_i = {4'd1, 4'd1, 4'd2};
    repeat (3) @(negedge clk);
    chk("rst_grant", 64'(grant_o), 64'h0);
    chk("rst_valid", 64'(tl_tx_valid_o), 64'h0);
    chk("rst_ready", 64'(pkt_ready_o), 64'h0);
    chk("rst_proto", 64'(proto_err_o), 64'h0);
    chk("rst_cons", 64'({hdr_consume_v_o, data_consume_v_o}), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // WRR with weights {2,1,1}: order 0,0,1,2,0,0,1,2
    for (int i = 0; i < 4; i++) load(0, 1'b1, 1'b1, mk_hdr(16'h10 + 16'(i), 1'b0, 10'd0));
    for (int i = 0; i < 2; i++) load(1, 1'b1, 1'b1, mk_hdr(16'h20 + 16'(i), 1'b0, 10'd0));
    for (int i = 0; i < 2; i++) load(2, 1'b1, 1'b1, mk_hdr(16'h30 + 16'(i), 1'b0, 10'd0));
    expb(0, 1, 1, mk_hdr(16'h10, 0, 0)); expc(3'b001, 3'b000, 36'h0);
    expb(0, 1, 1, mk_hdr(16'h11, 0, 0)); expc(3'b001, 3'b000, 36'h0);
    expb(1, 1, 1, mk_hdr(16'h20, 0, 0)); expc(3'b010, 3'b000, 36'h0);
    expb(2, 1, 1, mk_hdr(16'h30, 0, 0)); expc(3'b100, 3'b000, 36'h0);
    expb(0, 1, 1, mk_hdr(16'h12, 0, 0)); expc(3'b001, 3'b000, 36'h0);
    expb(0, 1, 1, mk_hdr(16'h13, 0, 0)); expc(3'b001, 3'b000, 36'h0);
    expb(1, 1, 1, mk_hdr(16'h21, 0, 0)); expc(3'b010, 3'b000, 36'h0);
    expb(2, 1, 1, mk_hdr(16'h31, 0, 0)); expc(3'b100, 3'b000, 36'h0);
    drain();

    // Posted MWr len=4 on Q2, two beats
    @(negedge clk);
    load(2, 1, 0, mk_hdr(16'h40, 1, 10'd4));
    load(2, 0, 1, mk_dat(16'h41));
    expb(2, 1, 0, mk_hdr(16'h40, 1, 10'd4));
    expb(2, 0, 1, mk_dat(16'h41));
    expc(3'b100, 3'b100, 36'h004000000);
    drain();
    @(negedge clk);
    chk("mwr_idle_grant", 64'(grant_o), 64'h0);
    chk("mwr_idle_valid", 64'(tl_tx_valid_o), 64'h0);

    // Q1 blocked by data credit while Q0 goes
    data_credit_ok_i[1] = 1'b0;
    load(1, 1, 1, mk_hdr(16'h50, 1, 10'd8));
    load(0, 1, 1, mk_hdr(16'h51, 0, 10'd0));
    expb(0, 1, 1, mk_hdr(16'h51, 0, 0)); expc(3'b001, 3'b000, 36'h0);
    drain();
    repeat (5) @(negedge clk);
    chk("credit_block_grant", 64'(grant_o), 64'h0);
    expb(1, 1, 1, mk_hdr(16'h50, 1, 10'd8)); expc(3'b010, 3'b010, 36'h000008000);
    data_credit_ok_i[1] = 1'b1;
    drain();

    // Downstream stall for 3 cycles mid-packet
    @(negedge clk);
    b0 = mon_beats;
    load(0, 1, 0, mk_hdr(16'h60, 1, 10'd2));
    load(0, 0, 0, mk_dat(16'h61));
    load(0, 0, 1, mk_dat(16'h62));
    expb(0, 1, 0, mk_hdr(16'h60, 1, 10'd2));
    expb(0, 0, 0, mk_dat(16'h61));
    expb(0, 0, 1, mk_dat(16'h62));
    expc(3'b001, 3'b001, 36'h000000002);
    wait_beats(b0 + 1);
    @(posedge clk); #2;
    tl_tx_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_grant", 64'(grant_o), 64'h1);
      chk("stall_valid", 64'(tl_tx_valid_o), 64'h1);
    end
    @(posedge clk); #2;
    tl_tx_ready_i = 1'b1;
    drain();

    // len=0 means 1024 DW; Q1 disabled by weight 0; Q0 non-sop head
    @(negedge clk);
    weight_i = {4'd1, 4'd0, 4'd2};
    load(1, 1, 1, mk_hdr(16'h70, 0, 10'd0));
    load(2, 1, 0, mk_hdr(16'h71, 1, 10'd0));
    load(2, 0, 1, mk_dat(16'h72));
    expb(2, 1, 0, mk_hdr(16'h71, 1, 10'd0));
    expb(2, 0, 1, mk_dat(16'h72));
    expc(3'b100, 3'b100, 36'h400000000);
    drain();
    repeat (10) @(negedge clk);
    chk("weight0_grant", 64'(grant_o), 64'h0);
    chk("proto_before", 64'(proto_err_o), 64'h0);
    load(0, 0, 1, mk_dat(16'h73));
    repeat (4) @(negedge clk);
    chk("proto_set", 64'(proto_err_o), 64'h1);
    chk("proto_no_grant", 64'(grant_o), 64'h0);
    rst_n = 1'b0;
    for (int q = 0; q < NQ; q++) src_q[q].delete();
    @(negedge clk);
    chk("proto_cleared", 64'(proto_err_o), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    weight_i = {4'd1, 4'd1, 4'd2};

    // Reset in the middle of a packet abandons it
    @(negedge clk);
    b0 = mon_beats;
    load(0, 1, 0, mk_hdr(16'h80, 1, 10'd3));
    load(0, 0, 0, mk_dat(16'h81));
    load(0, 0, 1, mk_dat(16'h82));
    expb(0, 1, 0, mk_hdr(16'h80, 1, 10'd3));
    expc(3'b001, 3'b001, 36'h000000003);
    wait_beats(b0 + 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    for (int q = 0; q < NQ; q++) src_q[q].delete();
    @(negedge clk);
    chk("midrst_grant", 64'(grant_o), 64'h0);
    chk("midrst_valid", 64'(tl_tx_valid_o), 64'h0);
    chk("midrst_cons", 64'(hdr_consume_v_o), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_leftover", 64'(exp_beat.size() + exp_cons.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
